tx_bf_ch: RTL and testbench
===========================

Name: tx_bf_ch

Overview:
- Per-channel transmit beamforming delay and pulse generator; the transmit-side counterpart of the per-channel receive DBF (coarse/fine delay plus apodisation).
- Holds a per-channel transmit focal delay table, written through the same address/write-enable LUT loading scheme as the receive channels.
- On a fire command, waits the looked-up delay, then drives a bipolar pulser (tx_p/tx_n) with a programmable burst.
- One instance per element; all channels share clk, rst_n, tx_start and the LUT bus, each with its own lut_cs.

Parameters:
ADDR_WD, 6, delay-table address width (depth 2^ADDR_WD focal/steer entries)
DLY_WD, 12, delay value width in clk cycles
HALF_PER, 4, cycles per pulse half-period (min 1)
BURST_LEN, 2, full pulse cycles per burst (min 1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
lut_cs  input  1  channel select for table write
lut_we  input  1  table write enable; write occurs when lut_cs & lut_we
lut_addr  input  ADDR_WD  write address; also the read (zone) address sampled at fire
lut_din  input  DLY_WD  delay value to write
ch_en  input  1  apodisation mask; 0 = channel muted
tx_start  input  1  single-cycle fire request
tx_abort  input  1  synchronous abort of the current firing
tx_p  output  1  positive pulser drive (registered)
tx_n  output  1  negative pulser drive (registered)
tx_busy  output  1  firing in progress
tx_done  output  1  one-cycle end-of-burst strobe

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_p, tx_n, tx_busy, tx_done = 0; counters 0. Table contents are undefined after power-up and not cleared by reset. Reset mid-burst kills outputs immediately.
- Table: synchronous write. Synchronous read with 1-cycle latency. Simultaneous write and fire-read to the same address returns the OLD value (read-first).
- States and transitions:
  - IDLE: on tx_start, latch lut_addr as read address and latch ch_en; go to LOAD.
  - LOAD: registered table data available; load dly_cnt; go to DELAY, or to PULSE if the delay is 0.
  - DELAY: decrement dly_cnt each cycle; at 1, go to PULSE.
  - PULSE: phase counter 0..2*HALF_PER-1 and cycle counter 0..BURST_LEN-1.
    - tx_p = 1 during the first HALF_PER cycles of each period; tx_n = 1 during the second HALF_PER cycles.
    - When the last tx_n cycle ends, go to DONE.
  - DONE: tx_done = 1 for one cycle; return to IDLE.
- Timing, with edge 0 = the edge sampling tx_start and D = table value:
  - tx_busy rises at edge 1.
  - tx_p first rises at edge 2+D.
  - The burst occupies 2*HALF_PER*BURST_LEN cycles.
  - tx_done = 1 and tx_busy = 0 at edge 2+D+2*HALF_PER*BURST_LEN.
- tx_p and tx_n are never high in the same cycle; both are 0 outside PULSE.
- Muted channel (latched ch_en = 0): identical state/timing and tx_done, but tx_p = tx_n = 0 throughout.
- tx_start while not IDLE: ignored (no retrigger, no queuing).
- tx_abort (any state except IDLE): next edge goes to IDLE with tx_p = tx_n = tx_busy = 0 and NO tx_done. Abort takes priority over tx_start in the same cycle.
- Table writes while busy are allowed; they do not affect the firing in progress, because the delay is already loaded.
- Delay wrap: D = 2^DLY_WD-1 is the maximum; the counter never wraps.

Test Plan:
- Reset defaults: table addr 3 = 0, fire at addr 3 with defaults → tx_p high edges 2–5, tx_n 6–9, tx_p 10–13, tx_n 14–17, tx_done at edge 18, tx_busy high edges 1–17.
- Delay: table addr 5 = 100, fire → tx_p rises edge 102, tx_done edge 118. Also fire addr 5 with a same-cycle write of 7 → old delay 100 used; a second fire uses 7 (tx_p at edge 9).
- Mute: ch_en = 0 at fire, D = 10 → tx_p/tx_n stay 0, tx_done still at edge 28.
- Retrigger: tx_start pulsed at edges 0 and 5 with D = 20 → a single burst only, tx_done at edge 38, no second burst.
- Abort: D = 0, tx_abort at edge 7 (during tx_n) → tx_n 0 and tx_busy 0 from edge 8, no tx_done. A new fire at edge 10 yields a normal burst.
- Async reset: assert rst_n = 0 mid-DELAY between edges → outputs 0 immediately. After release, fire → normal timing, with table contents retained.

Source files
------------

// File: rtl/tx_bf_ch.sv
// Per-channel transmit beamforming delay and bipolar pulse generator.
// A fire request samples the channel's focal delay table at lut_addr, waits
// that many clocks, then drives a BURST_LEN-period bipolar burst on tx_p/tx_n.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   lut_cs, lut_we      table write strobe (write when both high)
//   lut_addr, lut_din   table write address/data; lut_addr is also the zone read address at fire
//   ch_en               apodisation mask latched at fire (0 = muted)
//   tx_start, tx_abort  single-cycle fire request, synchronous abort
//   tx_p, tx_n          registered pulser drives
//   tx_busy, tx_done    firing in progress, one-cycle end-of-burst strobe
module tx_bf_ch #(
  parameter int unsigned ADDR_WD   = 6,
  parameter int unsigned DLY_WD    = 12,
  parameter int unsigned HALF_PER  = 4,
  parameter int unsigned BURST_LEN = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lut_cs,
  input  logic               lut_we,
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic [DLY_WD-1:0]  lut_din,
  input  logic               ch_en,
  input  logic               tx_start,
  input  logic               tx_abort,
  output logic               tx_p,
  output logic               tx_n,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int unsigned DEPTH  = 1 << ADDR_WD;
  localparam int unsigned PER    = 2 * HALF_PER;
  localparam int unsigned PH_WD  = $clog2(PER);
  localparam int unsigned CYC_WD = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DELAY, PULSE, DONE} state_t;

  state_t              state, state_d;
  logic [DLY_WD-1:0]   mem [DEPTH];
  logic [DLY_WD-1:0]   rd_data;
  logic [DLY_WD-1:0]   dly_cnt;
  logic [PH_WD-1:0]    phase;
  logic [CYC_WD-1:0]   cyc;
  logic                en_q;
  logic                fire;
  logic                phase_last;
  logic                burst_end;

  // Abort wins over a same-cycle fire request.
  assign fire       = (state == IDLE) && tx_start && !tx_abort;
  assign phase_last = (phase == PH_WD'(PER - 1));
  assign burst_end  = phase_last && (cyc == CYC_WD'(BURST_LEN - 1));

  // Delay table: read-first, so a same-edge write to the fire address returns the old value.
  always_ff @(posedge clk) begin
    if (fire) rd_data <= mem[lut_addr];
    if (lut_cs && lut_we) mem[lut_addr] <= lut_din;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (fire) state_d = LOAD;
      LOAD:    state_d = (rd_data == '0) ? PULSE : DELAY;
      DELAY:   if (dly_cnt == DLY_WD'(1)) state_d = PULSE;
      PULSE:   if (burst_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tx_abort && (state != IDLE)) state_d = IDLE;
  end

  // Delay counter, burst phase/cycle counters and latched mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
      phase   <= '0;
      cyc     <= '0;
      en_q    <= 1'b0;
    end else begin
      if (fire) en_q <= ch_en;
      if (state == LOAD)       dly_cnt <= rd_data;
      else if (state == DELAY) dly_cnt <= dly_cnt - DLY_WD'(1);
      if (state == PULSE) begin
        if (phase_last) begin
          phase <= '0;
          cyc   <= (cyc == CYC_WD'(BURST_LEN - 1)) ? '0 : cyc + CYC_WD'(1);
        end else begin
          phase <= phase + PH_WD'(1);
        end
      end else begin
        phase <= '0;
        cyc   <= '0;
      end
    end
  end

  // Registered outputs decoded from the current state, one cycle behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_p    <= 1'b0;
      tx_n    <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_busy <= (state == LOAD) || (state == DELAY) || (state == PULSE);
      tx_p    <= (state == PULSE) && en_q && (phase <  PH_WD'(HALF_PER));
      tx_n    <= (state == PULSE) && en_q && (phase >= PH_WD'(HALF_PER));
      tx_done <= (state == DONE) && !tx_abort;
    end
  end

endmodule

// File: tb/tb_tx_bf_ch.sv
// Bench for tx_bf_ch: vector table of fires plus hand sequences, checked
// cycle by cycle against an expected-burst scoreboard.
module tb_tx_bf_ch;

  localparam int HP = 4;
  localparam int BL = 2;
  localparam int BURST = 2 * HP * BL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lut_cs = 1'b0, lut_we = 1'b0;
  logic [5:0] lut_addr = '0;
  logic [11:0] lut_din = '0;
  logic       ch_en = 1'b1, tx_start = 1'b0, tx_abort = 1'b0;
  logic       tx_p, tx_n, tx_busy, tx_done;

  tx_bf_ch dut (
    .clk(clk), .rst_n(rst_n), .lut_cs(lut_cs), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_din(lut_din), .ch_en(ch_en),
    .tx_start(tx_start), .tx_abort(tx_abort),
    .tx_p(tx_p), .tx_n(tx_n), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t0; int d; bit en; int ab; } exp_t;
  typedef struct { logic [5:0] addr; int d; bit en; } vec_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_chk = 0;
  bit   mon_on = 1'b0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: {p,n,busy,done} got %b expected %b", nm, cyc, act, exp);
  endtask

  // Expected outputs at edge r relative to the fire edge of the front record.
  always @(negedge clk) begin : mon
    logic [3:0] e;
    int r, ps, de, stp, ph;
    bit retire;
    if (mon_on) begin
      e = 4'b0000;
      retire = 1'b0;
      if (sb.size() > 0) begin
        r   = cyc - sb[0].t0;
        ps  = 2 + sb[0].d;
        de  = ps + BURST;
        stp = (sb[0].ab >= 0) ? sb[0].ab + 1 : de;
        e[1] = (r >= 1) && (r < stp);
        if (r >= ps && r < stp) begin
          ph = (r - ps) % (2 * HP);
          e[3] = sb[0].en && (ph < HP);
          e[2] = sb[0].en && (ph >= HP);
        end
        e[0] = (sb[0].ab < 0) && (r == de);
        retire = (r >= stp);
      end
      check("burst", {tx_p, tx_n, tx_busy, tx_done}, e);
      if (retire) void'(sb.pop_front());
    end
  end

  // Callers sit just after a negedge; each task returns at a later negedge.
  task automatic write(input logic [5:0] a, input int d);
    lut_cs = 1'b1; lut_we = 1'b1; lut_addr = a; lut_din = 12'(d);
    @(negedge clk);
    lut_cs = 1'b0; lut_we = 1'b0;
  endtask

  task automatic fire(input logic [5:0] a, input bit en, input int d, input int ab);
    exp_t x;
    lut_addr = a; ch_en = en; tx_start = 1'b1;
    x.t0 = cyc + 1; x.d = d; x.en = en; x.ab = ab;
    sb.push_back(x);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL timeout: burst still pending after %0d cycles, %0d left", budget, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[6];
  int   t0;

  initial begin
    vecs[0] = '{6'd3,  0,    1'b1};
    vecs[1] = '{6'd5,  100,  1'b1};
    vecs[2] = '{6'd9,  10,   1'b0};
    vecs[3] = '{6'd63, 1,    1'b1};
    vecs[4] = '{6'd0,  4095, 1'b1};
    vecs[5] = '{6'd17, 2,    1'b1};

    repeat (3) @(negedge clk);
    check("reset", {tx_p, tx_n, tx_busy, tx_done}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;

    for (int i = 0; i < 6; i++) begin
      write(vecs[i].addr, vecs[i].d);
      fire(vecs[i].addr, vecs[i].en, vecs[i].d, -1);
      wait_idle(5000);
    end

    // Same-edge write of 7 and fire at addr 5: old delay 100 is used, then 7.
    lut_cs = 1'b1; lut_we = 1'b1; lut_din = 12'd7;
    fire(6'd5, 1'b1, 100, -1);
    lut_cs = 1'b0; lut_we = 1'b0;
    wait_idle(500);
    fire(6'd5, 1'b1, 7, -1);
    wait_idle(500);

    // Retrigger at edge 5 is ignored; idle cycles afterwards must stay quiet.
    write(6'd21, 20);
    fire(6'd21, 1'b1, 20, -1);
    repeat (4) @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle(500);
    repeat (30) @(negedge clk);

    // Abort sampled at edge 7 during tx_n, then a fresh fire at edge 10.
    fire(6'd3, 1'b1, 0, 7);
    t0 = cyc;
    repeat (6) @(negedge clk);
    tx_abort = 1'b1;
    @(negedge clk);
    tx_abort = 1'b0;
    repeat (2) @(negedge clk);
    if (cyc != t0 + 9) begin
      n_chk++;
      $display("FAIL abort_seq: refire at cycle %0d expected %0d", cyc, t0 + 9);
    end
    fire(6'd3, 1'b1, 0, -1);
    wait_idle(500);

    // Async reset mid-delay, then the retained table value is used again.
    write(6'd20, 30);
    fire(6'd20, 1'b1, 30, -1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", {tx_p, tx_n, tx_busy, tx_done}, 4'b0000);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    fire(6'd20, 1'b1, 30, -1);
    wait_idle(500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
